// File: rtl/timer_core.sv
// Prescaled down-counting timer with auto-reload and a sticky expiry flag.
// Holds the CTRL/PERIOD/PRESCALE registers written through one-hot decoder strobes.
module timer_core #(
    parameter int WIDTH  = 16,
    parameter int PWIDTH = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [3:0]        i_wr_sel,
    input  logic [WIDTH-1:0]  i_wdata,
    output logic [WIDTH-1:0]  o_count,
    output logic [WIDTH-1:0]  o_period,
    output logic [PWIDTH-1:0] o_prescale,
    output logic [2:0]        o_ctrl,
    output logic              o_running,
    output logic              o_flag,
    output logic              o_irq
);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    state_t            r_state;
    logic [WIDTH-1:0]  r_count;
    logic [WIDTH-1:0]  r_period;
    logic [PWIDTH-1:0] r_prescale;
    logic [PWIDTH-1:0] r_pscnt;
    logic [2:0]        r_ctrl;
    logic              r_running;
    logic              r_flag;

    logic w_ctrl_wr;
    logic w_disable;
    logic w_start;
    logic w_clear;
    logic w_tick;
    logic w_expire;
    logic w_unused;

    assign w_ctrl_wr = i_wr_sel[0];
    assign w_disable = w_ctrl_wr & ~i_wdata[0];
    assign w_start   = w_ctrl_wr &  i_wdata[0];
    assign w_clear   = w_ctrl_wr &  i_wdata[3];
    // A disabling CTRL write wins over a tick landing on the same edge.
    assign w_tick    = (r_state == ST_RUN) && !w_disable && (r_pscnt == r_prescale);
    assign w_expire  = w_tick && (r_count == '0);
    assign w_unused  = i_wr_sel[3];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_count    <= '0;
            r_period   <= '0;
            r_prescale <= '0;
            r_pscnt    <= '0;
            r_ctrl     <= '0;
            r_running  <= 1'b0;
            r_flag     <= 1'b0;
        end else begin
            if (i_wr_sel[1]) r_period   <= i_wdata;
            if (i_wr_sel[2]) r_prescale <= i_wdata[PWIDTH-1:0];
            if (w_ctrl_wr)   r_ctrl     <= i_wdata[2:0];

            if (w_expire)     r_flag <= 1'b1;
            else if (w_clear) r_flag <= 1'b0;

            if (w_disable) begin
                r_state   <= ST_IDLE;
                r_running <= 1'b0;
                r_pscnt   <= '0;
            end else begin
                unique case (r_state)
                    ST_IDLE: begin
                        if (i_wr_sel[1]) r_count <= i_wdata;
                        if (w_start) begin
                            r_count   <= r_period;
                            r_pscnt   <= '0;
                            r_state   <= ST_RUN;
                            r_running <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (w_tick) begin
                            r_pscnt <= '0;
                            if (r_count != '0) begin
                                r_count <= r_count - WIDTH'(1);
                            end else if (r_ctrl[1]) begin
                                r_count <= r_period;
                            end else begin
                                // Overrides the stored enable bit so software sees the one-shot finished.
                                r_ctrl[0] <= 1'b0;
                                r_state   <= ST_DONE;
                                r_running <= 1'b0;
                            end
                        end else begin
                            r_pscnt <= r_pscnt + PWIDTH'(1);
                        end
                    end
                    ST_DONE: begin
                        if (w_start) begin
                            r_count   <= r_period;
                            r_pscnt   <= '0;
                            r_state   <= ST_RUN;
                            r_running <= 1'b1;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign o_count    = r_count;
    assign o_period   = r_period;
    assign o_prescale = r_prescale;
    assign o_ctrl     = r_ctrl;
    assign o_running  = r_running;
    assign o_flag     = r_flag;
    assign o_irq      = r_flag & r_ctrl[2];

endmodule
